// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   NIBBLE_W     width of one adder slice (the external 4-bit ripple adder)
//   nsa_state_t  controller FSM state encoding
//   clog2()      bit width needed to count n values (0 for n <= 1)
package nibble_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << w) < n) w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/nibble_shreg.sv
// Right-shift register that moves one nibble per shift.
//   clk    clock, rising edge
//   clr    synchronous clear (highest priority)
//   load   parallel load of din
//   shift  shift right by one nibble, sin entering at the top
//   din    parallel load value (WIDTH bits)
//   sin    serial nibble input
//   q      register contents; q[3:0] is the nibble leaving next
module nibble_shreg
   import nibble_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                load,
   input  logic                shift,
   input  logic [WIDTH-1:0]    din,
   input  logic [NIBBLE_W-1:0] sin,
   output logic [WIDTH-1:0]    q
);

   generate
      if (WIDTH == NIBBLE_W) begin : g_single
         always_ff @(posedge clk) begin
            if (clr)        q <= '0;
            else if (load)  q <= din;
            else if (shift) q <= sin;
         end
      end else begin : g_multi
         always_ff @(posedge clk) begin
            if (clr)        q <= '0;
            else if (load)  q <= din;
            else if (shift) q <= {sin, q[WIDTH-1:NIBBLE_W]};
         end
      end
   endgenerate

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that performs a WIDTH-bit addition through an external 4-bit
// ripple adder, one nibble per cycle, LSB nibble first.
// Optional feature macro: NSA_SUB_EN adds op_sub (A-B via ~B and carry-in 1).
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready high only when idle
//   in_a, in_b, in_cin    operands and carry-in of the whole operation
//   op_sub                (NSA_SUB_EN only) 1 = subtract, captured on accept
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     assembled sum and carry out of the top nibble
//   add_a, add_b, add_cin drive the external adder (0 outside RUN)
//   add_s, add_cout       combinational results from the external adder
module nibble_serial_adder_ctrl
   import nibble_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   input  logic                in_cin,
`ifdef NSA_SUB_EN
   input  logic                op_sub,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_sum,
   output logic                out_cout,
   output logic [NIBBLE_W-1:0] add_a,
   output logic [NIBBLE_W-1:0] add_b,
   output logic                add_cin,
   input  logic [NIBBLE_W-1:0] add_s,
   input  logic                add_cout
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = (NIB > 1) ? clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

   generate
      if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
         $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   nsa_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             carry_reg;
   logic             sub_reg;
   logic             first_cin;
   logic             accept;
   logic             running;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             unused_hi;

   assign accept  = (state == IDLE) && in_valid;
   assign running = (state == RUN);

   // Subtraction is A + ~B + 1: the inversion happens per nibble on add_b,
   // the +1 enters as the first-nibble carry.
`ifdef NSA_SUB_EN
   assign first_cin = op_sub ? 1'b1 : in_cin;
   always_ff @(posedge clk) begin
      if (accept) sub_reg <= op_sub;
   end
`else
   assign first_cin = in_cin;
   assign sub_reg   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         out_valid <= 1'b0;
         out_cout  <= 1'b0;
      end else begin
         if (accept)       cnt <= '0;
         else if (running) cnt <= cnt + 1'b1;

         if (running && cnt == LAST) begin
            out_valid <= 1'b1;
            out_cout  <= add_cout;
         end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Carry between nibbles; only meaningful while RUN, so no reset.
   always_ff @(posedge clk) begin
      if (accept)       carry_reg <= first_cin;
      else if (running) carry_reg <= add_cout;
   end

   nibble_shreg #(.WIDTH(WIDTH)) u_a_reg (
      .clk   (clk),
      .clr   (1'b0),
      .load  (accept),
      .shift (running),
      .din   (in_a),
      .sin   ('0),
      .q     (a_q)
   );

   nibble_shreg #(.WIDTH(WIDTH)) u_b_reg (
      .clk   (clk),
      .clr   (1'b0),
      .load  (accept),
      .shift (running),
      .din   (in_b),
      .sin   ('0),
      .q     (b_q)
   );

   // Each adder nibble enters at the top; after NIB shifts the LSB nibble
   // has reached bit 0 and the register holds the assembled sum.
   nibble_shreg #(.WIDTH(WIDTH)) u_sum_reg (
      .clk   (clk),
      .clr   (rst),
      .load  (1'b0),
      .shift (running),
      .din   ('0),
      .sin   (add_s),
      .q     (sum_q)
   );

   assign out_sum = sum_q;

   assign add_a   = running ? a_q[NIBBLE_W-1:0] : '0;
   assign add_b   = running ? (b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_reg}}) : '0;
   assign add_cin = running & carry_reg;

   // Only the low nibble of the operand registers feeds the adder.
   assign unused_hi = |{a_q >> NIBBLE_W, b_q >> NIBBLE_W};

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a, in_b;
   logic             in_cin;
`ifdef NSA_SUB_EN
   logic             op_sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic [3:0]       add_a, add_b, add_s;
   logic             add_cin, add_cout;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Behavioural model of the external 4-bit ripple adder.
   always_comb {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef NSA_SUB_EN
      .op_sub    (op_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full operation: accept, wait for result, hold out_ready low for
   // 'hold' cycles, then handshake. With 'junk' set, in_valid stays high
   // with changing data until the result has been consumed.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int hold, input bit junk);
      logic [WIDTH:0] rsum;
      int lat;
      if (sub) rsum = {1'b0, a} + {1'b0, ~b} + 17'd1;
      else     rsum = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
      chk("idle_add_a", add_a, 0);
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
`ifdef NSA_SUB_EN
      op_sub = sub;
`endif
      @(posedge clk);
      @(negedge clk);
      if (junk) begin in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom); end
      else in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < NIB + 8) begin
         chk("run_ready", in_ready, 0);
         @(posedge clk); lat++; @(negedge clk);
         if (junk) begin in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); end
      end
      chk("latency", lat, NIB);
      chk("sum", out_sum, rsum[WIDTH-1:0]);
      chk("cout", out_cout, rsum[WIDTH]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_ready", in_ready, 0);
         chk("hold_sum", out_sum, rsum[WIDTH-1:0]);
         chk("hold_cout", out_cout, rsum[WIDTH]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_ready", in_ready, 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef NSA_SUB_EN
      op_sub = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_cout", out_cout, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_add_cin", add_cin, 0);
      chk("rst_ready", in_ready, 1);
      rst = 1'b0;

      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 5, 1'b0);

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1357; in_cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_add_a", add_a, 0);
      for (int i = 0; i < NIB + 2; i++) begin
         @(posedge clk); @(negedge clk);
         chk("mid_rst_quiet", out_valid, 0);
      end
      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

      // Requests presented while busy are ignored.
      do_op(16'h4321, 16'h0F0F, 1'b1, 1'b0, 2, 1'b1);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0);

`ifdef NSA_SUB_EN
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
      do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
`endif

      for (int k = 0; k < 24; k++) begin
         logic sub_r;
`ifdef NSA_SUB_EN
         sub_r = 1'($urandom);
`else
         sub_r = 1'b0;
`endif
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sub_r,
               $urandom_range(0, 3), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
